// File: rtl/pos_stream_reader.sv
// Streams a contiguous block of x/y/z particle positions out of three lockstep RAMs.
// Define POS_READER_WRAP_EN to accept blocks that run past DEPTH-1 and wrap to 0.
module pos_stream_reader #(
   parameter int DEPTH      = 512,
   parameter int ADDR_WIDTH = 9,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   num_particles,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_rden,
   output logic                  mem_wren,
   input  logic [31:0]           mem_qx,
   input  logic [31:0]           mem_qy,
   input  logic [31:0]           mem_qz,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_posx,
   output logic [31:0]           out_posy,
   output logic [31:0]           out_posz,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int AW = ADDR_WIDTH;
   localparam int RW = ADDR_WIDTH + 1;
   localparam int OW = ADDR_WIDTH + 2;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] cur_addr_q, cur_addr_d;
   logic [RW-1:0] remain_q, remain_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic [1:0]         tag_v_q, tag_v_d;
   logic [1:0]         tag_last_q, tag_last_d;
   logic [1:0][AW-1:0] tag_idx_q, tag_idx_d;

   logic [31:0]           fx_q [FIFO_DEPTH];
   logic [31:0]           fx_d [FIFO_DEPTH];
   logic [31:0]           fy_q [FIFO_DEPTH];
   logic [31:0]           fy_d [FIFO_DEPTH];
   logic [31:0]           fz_q [FIFO_DEPTH];
   logic [31:0]           fz_d [FIFO_DEPTH];
   logic [AW-1:0]         fidx_q [FIFO_DEPTH];
   logic [AW-1:0]         fidx_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] flast_q, flast_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [CW-1:0] occ;
   logic [AW-1:0] next_addr;
   logic          reject;
   logic          issue;
   logic          accept;
   logic          push;
   logic          pop;
   logic          head_last;

`ifdef POS_READER_WRAP_EN
   assign reject = 1'b0;
`else
   assign reject = (OW'(base_addr) + OW'(num_particles)) > OW'(DEPTH);
`endif

   // occupancy counts reads still in the RAM pipe so the FIFO can never overflow
   assign occ       = cnt_q + CW'(tag_v_q[0]) + CW'(tag_v_q[1]);
   assign next_addr = (cur_addr_q == AW'(DEPTH - 1)) ? '0 : cur_addr_q + AW'(1);
   assign push      = tag_v_q[1];
   assign pop       = out_valid & out_ready;
   assign head_last = flast_q[rd_ptr_q];

   assign out_valid   = (cnt_q != '0);
   assign out_posx    = fx_q[rd_ptr_q];
   assign out_posy    = fy_q[rd_ptr_q];
   assign out_posz    = fz_q[rd_ptr_q];
   assign out_index   = fidx_q[rd_ptr_q];
   assign out_last    = head_last;
   assign mem_address = cur_addr_q;
   assign mem_rden    = issue;
   assign mem_wren    = 1'b0;
   assign busy        = (state_q != IDLE);
   assign done        = done_q | accept;
   assign err         = err_q;

   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      remain_d   = remain_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      issue      = 1'b0;
      accept     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (num_particles == '0) begin
                  done_d = 1'b1;
               end else if (reject) begin
                  err_d = 1'b1;
               end else begin
                  state_d    = ISSUE;
                  cur_addr_d = base_addr;
                  remain_d   = num_particles;
               end
            end
         end
         ISSUE: begin
            if (occ < CW'(FIFO_DEPTH)) begin
               issue      = 1'b1;
               cur_addr_d = next_addr;
               remain_d   = remain_q - RW'(1);
               if (remain_q == RW'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && head_last) begin
               state_d = IDLE;
               accept  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tag_v_d      = {tag_v_q[0], issue};
      tag_last_d   = {tag_last_q[0], (remain_q == RW'(1))};
      tag_idx_d[0] = cur_addr_q;
      tag_idx_d[1] = tag_idx_q[0];
      fx_d         = fx_q;
      fy_d         = fy_q;
      fz_d         = fz_q;
      fidx_d       = fidx_q;
      flast_d      = flast_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      if (push) begin
         fx_d[wr_ptr_q]    = mem_qx;
         fy_d[wr_ptr_q]    = mem_qy;
         fz_d[wr_ptr_q]    = mem_qz;
         fidx_d[wr_ptr_q]  = tag_idx_q[1];
         flast_d[wr_ptr_q] = tag_last_q[1];
         wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_addr_q <= '0;
         remain_q   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         tag_v_q    <= '0;
         tag_last_q <= '0;
         tag_idx_q  <= '0;
         fx_q       <= '{default: '0};
         fy_q       <= '{default: '0};
         fz_q       <= '{default: '0};
         fidx_q     <= '{default: '0};
         flast_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         remain_q   <= remain_d;
         done_q     <= done_d;
         err_q      <= err_d;
         tag_v_q    <= tag_v_d;
         tag_last_q <= tag_last_d;
         tag_idx_q  <= tag_idx_d;
         fx_q       <= fx_d;
         fy_q       <= fy_d;
         fz_q       <= fz_d;
         fidx_q     <= fidx_d;
         flast_q    <= flast_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end
endmodule

// File: tb/tb_pos_stream_reader.sv
// Bench for pos_stream_reader: a queue model of the block read feeds a scoreboard
// that a negedge monitor drains; directed cases check timing and corner behaviour.
module tb_pos_stream_reader;
   localparam int DEPTH = 512;
   localparam int AW    = 9;

   typedef struct packed {
      logic [31:0]   x;
      logic [31:0]   y;
      logic [31:0]   z;
      logic [AW-1:0] idx;
      logic          last;
   } beat_t;

   logic          clock = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   num_particles;
   logic [AW-1:0] mem_address;
   logic          mem_rden;
   logic          mem_wren;
   logic [31:0]   mem_qx, mem_qy, mem_qz;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_posx, out_posy, out_posz;
   logic [AW-1:0] out_index;
   logic          out_last;
   logic          busy, done, err;

   pos_stream_reader dut (
      .clock(clock), .rst(rst), .start(start),
      .base_addr(base_addr), .num_particles(num_particles),
      .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren),
      .mem_qx(mem_qx), .mem_qy(mem_qy), .mem_qz(mem_qz),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_posx(out_posx), .out_posy(out_posy), .out_posz(out_posz),
      .out_index(out_index), .out_last(out_last),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clock = ~clock;

   // RAM model: address registered on read, data registered once more
   logic [31:0]   ramx [DEPTH];
   logic [31:0]   ramy [DEPTH];
   logic [31:0]   ramz [DEPTH];
   logic [AW-1:0] ram_a = '0;
   always @(posedge clock) begin
      if (mem_rden) ram_a <= mem_address;
      mem_qx <= ramx[ram_a];
      mem_qy <= ramy[ram_a];
      mem_qz <= ramz[ram_a];
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int    tests = 0;
   int    fails = 0;
   int    t0 = 0;
   beat_t exp_q[$];
   int    done_log[$];
   int    err_log[$];
   int    rden_log[$];
   int    idx_log[$];
   int    beat_log[$];
   bit    busy_seen;
   int    busy_last;
   bit    wren_seen;
   bit    hold_prev = 1'b0;
   beat_t held;

   initial begin
      beat_t got, want;
      forever begin
         @(negedge clock);
         if (rst) begin
            hold_prev = 1'b0;
         end else begin
            got.x = out_posx; got.y = out_posy; got.z = out_posz;
            got.idx = out_index; got.last = out_last;
            if (hold_prev) begin
               tests++;
               if (!out_valid || got != held) begin
                  fails++;
                  $display("FAIL stall_hold: got v=%0d idx=%0d x=%h, need v=1 idx=%0d x=%h",
                           out_valid, got.idx, got.x, held.idx, held.x);
               end
            end
            hold_prev = out_valid && !out_ready;
            held = got;
            if (out_valid && out_ready) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL beat_extra: got idx=%0d, need no beat", got.idx);
               end else begin
                  want = exp_q.pop_front();
                  if (got != want) begin
                     fails++;
                     $display("FAIL beat: got idx=%0d x=%h y=%h z=%h last=%0d, need idx=%0d x=%h y=%h z=%h last=%0d",
                              got.idx, got.x, got.y, got.z, got.last,
                              want.idx, want.x, want.y, want.z, want.last);
                  end
               end
               idx_log.push_back(int'(got.idx));
               beat_log.push_back(cyc - t0);
            end
            if (done) done_log.push_back(cyc - t0);
            if (err) err_log.push_back(cyc - t0);
            if (mem_rden) rden_log.push_back(cyc - t0);
            if (busy) begin busy_seen = 1'b1; busy_last = cyc - t0; end
            if (mem_wren) wren_seen = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, need %0d", name, got, want);
      end
   endtask

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic clear_logs();
      done_log.delete(); err_log.delete(); rden_log.delete();
      idx_log.delete(); beat_log.delete();
      busy_seen = 1'b0; busy_last = -1; wren_seen = 1'b0;
   endtask

   // expected outcome from the block rules: nothing, an error, or cnt beats
   task automatic run(input int base, input int cnt, input int mode, input int start2);
      int    k, tail, nb, ne, nd, a;
      beat_t b;
      clear_logs();
      nb = 0; ne = 0; nd = 0;
      if (cnt == 0) begin
         nd = 1;
      end else begin
`ifndef POS_READER_WRAP_EN
         if (base + cnt > DEPTH) ne = 1;
`endif
         if (ne == 0) begin
            nd = 1;
            nb = cnt;
            for (int i = 0; i < cnt; i++) begin
               a = (base + i) % DEPTH;
               b.x = ramx[a]; b.y = ramy[a]; b.z = ramz[a];
               b.idx = AW'(a);
               b.last = (i == cnt - 1);
               exp_q.push_back(b);
            end
         end
      end
      @(posedge clock); #1;
      t0 = cyc;
      base_addr = AW'(base);
      num_particles = (AW + 1)'(cnt);
      k = 0; tail = 0;
      forever begin
         start = (k == 0) || (k == start2);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = !(k >= 3 && k <= 10);
         endcase
         @(posedge clock); #1;
         if (done_log.size() + err_log.size() != 0) tail++;
         if (tail > 4) break;
         if (k > 3000) begin
            tests++; fails++;
            $display("FAIL run_timeout: got no done/err in %0d cycles, need one", k);
            break;
         end
         k++;
      end
      start = 1'b0;
      out_ready = 1'b1;
      chk("done_count", done_log.size(), nd);
      chk("err_count", err_log.size(), ne);
      chk("read_count", rden_log.size(), nb);
      chk("beats_left", exp_q.size(), 0);
      chk("wren_seen", int'(wren_seen), 0);
      exp_q.delete();
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; base_addr = '0; num_particles = '0; out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ramx[i] = 32'(i); ramy[i] = 32'(i + 'h100); ramz[i] = 32'(i + 'h200);
      end
      @(posedge clock);
      @(negedge clock);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_rden", int'(mem_rden), 0);
      chk("rst_wren", int'(mem_wren), 0);
      chk("rst_addr", int'(mem_address), 0);
      chk("rst_index", int'(out_index), 0);
      chk("rst_posx", int'(out_posx), 0);
      chk("rst_last", int'(out_last), 0);
      repeat (2) @(posedge clock);
      #1 rst = 1'b0;

      // basic timing
      run(5, 3, 0, -1);
      for (int i = 0; i < 3; i++) begin
         chk("basic_beat_cycle", qat(beat_log, i), 4 + i);
         chk("basic_beat_index", qat(idx_log, i), 5 + i);
      end
      chk("basic_first_rden", qat(rden_log, 0), 1);
      chk("basic_done_cycle", qat(done_log, 0), 6);
      chk("basic_busy_last", busy_last, 6);

      // backpressure
      run(0, 8, 2, -1);
      n = 0;
      foreach (rden_log[i]) if (rden_log[i] <= 10) n++;
      chk("bp_reads_while_stalled", n, 4);
      chk("bp_fourth_read", qat(rden_log, 3), 4);
      chk("bp_first_beat", qat(beat_log, 0), 11);
      chk("bp_beats", idx_log.size(), 8);

      // zero count
      run(7, 0, 0, -1);
      chk("zero_done_cycle", qat(done_log, 0), 1);
      chk("zero_busy_seen", int'(busy_seen), 0);

      // overflow
      run(510, 4, 1, -1);
`ifdef POS_READER_WRAP_EN
      chk("ovf_idx0", qat(idx_log, 0), 510);
      chk("ovf_idx1", qat(idx_log, 1), 511);
      chk("ovf_idx2", qat(idx_log, 2), 0);
      chk("ovf_idx3", qat(idx_log, 3), 1);
`else
      chk("ovf_err_cycle", qat(err_log, 0), 1);
      chk("ovf_busy_seen", int'(busy_seen), 0);
`endif

      // reset in the middle of a count-16 read
      clear_logs();
      for (int i = 0; i < 16; i++) begin
         beat_t b;
         b.x = ramx[i]; b.y = ramy[i]; b.z = ramz[i];
         b.idx = AW'(i); b.last = (i == 15);
         exp_q.push_back(b);
      end
      @(posedge clock); #1;
      t0 = cyc; base_addr = '0; num_particles = 10'd16; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         start = (k == 0);
         @(posedge clock); #1;
      end
      start = 1'b0;
      rst = 1'b1;
      @(posedge clock); #1;
      rst = 1'b0;
      exp_q.delete();
      clear_logs();
      @(negedge clock);
      chk("rst_mid_valid", int'(out_valid), 0);
      chk("rst_mid_busy", int'(busy), 0);
      repeat (6) @(posedge clock);
      #1;
      chk("rst_mid_no_done", done_log.size(), 0);
      chk("rst_mid_no_reads", rden_log.size(), 0);
      chk("rst_mid_no_beats", idx_log.size(), 0);
      run(0, 2, 0, -1);
      chk("rst_new_beats", idx_log.size(), 2);
      chk("rst_new_idx0", qat(idx_log, 0), 0);
      chk("rst_new_idx1", qat(idx_log, 1), 1);

      // start while busy is ignored
      run(100, 4, 1, 2);
      chk("busy_start_beats", idx_log.size(), 4);

      // randomized requests against fresh RAM contents
      for (int i = 0; i < DEPTH; i++) begin
         ramx[i] = $urandom; ramy[i] = $urandom; ramz[i] = $urandom;
      end
      for (int t = 0; t < 30; t++) begin
         int b, c;
         b = $urandom_range(0, DEPTH - 1);
         if ($urandom_range(0, 3) == 0) b = DEPTH - 1 - $urandom_range(0, 10);
         c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : $urandom_range(1, 40);
         run(b, c, $urandom_range(0, 1), -1);
      end
      run(0, DEPTH, 1, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
